// File: rtl/sdram_responder_if.sv
// Command/data bus between an SDRAM controller (master) and the emulated device (slave).
// Signal names follow the device pin names so existing controller code maps one-to-one.
interface sdram_responder_if;
    logic        sd_ncs;
    logic        sd_nras;
    logic        sd_ncas;
    logic        sd_nwe;
    logic [1:0]  sd_ba;
    logic [12:0] sd_a;
    logic        sd_dqml;
    logic        sd_dqmh;
    logic [15:0] sd_dq_in;
    logic [15:0] sd_dq_out;
    logic        sd_dq_oe;
    logic [12:0] mode_reg;
    logic [15:0] rfsh_count;
    logic        proto_err;

    modport master (
        output sd_ncs, sd_nras, sd_ncas, sd_nwe, sd_ba, sd_a, sd_dqml, sd_dqmh, sd_dq_in,
        input  sd_dq_out, sd_dq_oe, mode_reg, rfsh_count, proto_err
    );

    modport slave (
        input  sd_ncs, sd_nras, sd_ncas, sd_nwe, sd_ba, sd_a, sd_dqml, sd_dqmh, sd_dq_in,
        output sd_dq_out, sd_dq_oe, mode_reg, rfsh_count, proto_err
    );
endinterface

// File: rtl/sdram_responder.sv
// Device-side emulation of a 16-bit SDR SDRAM: command decode, mode register, per-bank
// open rows, and burst reads/writes against an internal synchronous block RAM.
module sdram_responder #(
    parameter int MEM_AW = 14,
    parameter int COL_W  = 9,
    parameter int ROW_W  = 13
) (
    input  logic             clk,
    input  logic             init,
    sdram_responder_if.slave bus
);
    localparam int FULL_W = 2 + ROW_W + COL_W;

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Command decode
    logic [2:0] w_rcw;
    logic       w_cmd_act, w_cmd_rd, w_cmd_wr, w_cmd_pre, w_cmd_ref, w_cmd_lmr;

    assign w_rcw     = {bus.sd_nras, bus.sd_ncas, bus.sd_nwe};
    assign w_cmd_act = ~bus.sd_ncs && (w_rcw == 3'b011);
    assign w_cmd_rd  = ~bus.sd_ncs && (w_rcw == 3'b101);
    assign w_cmd_wr  = ~bus.sd_ncs && (w_rcw == 3'b100);
    assign w_cmd_pre = ~bus.sd_ncs && (w_rcw == 3'b010);
    assign w_cmd_ref = ~bus.sd_ncs && (w_rcw == 3'b001);
    assign w_cmd_lmr = ~bus.sd_ncs && (w_rcw == 3'b000);

    // Mode register fields
    logic [12:0] r_mode;
    logic [2:0]  w_bl_mask;
    logic        w_ilv;
    logic        w_cl3;
    logic        w_single_wr;

    always_comb begin
        case (r_mode[2:0])
            3'b001:  w_bl_mask = 3'd1;
            3'b010:  w_bl_mask = 3'd3;
            3'b011:  w_bl_mask = 3'd7;
            default: w_bl_mask = 3'd0;
        endcase
    end

    assign w_ilv       = r_mode[3];
    assign w_cl3       = (r_mode[6:4] == 3'd3);
    assign w_single_wr = r_mode[9];

    // Bank state
    logic [3:0]       r_open;
    logic [ROW_W-1:0] r_row [4];
    logic             w_bank_ok;
    logic             w_new_rd, w_new_wr, w_new_rw;
    logic [2:0]       w_new_mask;

    assign w_bank_ok  = r_open[bus.sd_ba];
    assign w_new_rd   = w_cmd_rd && w_bank_ok;
    assign w_new_wr   = w_cmd_wr && w_bank_ok;
    assign w_new_rw   = w_new_rd || w_new_wr;
    assign w_new_mask = (w_cmd_wr && w_single_wr) ? 3'd0 : w_bl_mask;

    // Burst engine context; r_k is the index of the next beat to issue
    logic [1:0]       r_bank;
    logic [ROW_W-1:0] r_brow;
    logic [COL_W-1:0] r_col;
    logic [2:0]       r_k;
    logic [2:0]       r_mask;
    logic             r_ilv;
    logic             r_ap;
    logic             r_cl3;

    logic [2:0]       w_eng_off;
    logic [COL_W-1:0] w_eng_col;
    logic [COL_W-1:0] w_mask_ext;

    assign w_mask_ext = {{(COL_W-3){1'b0}}, r_mask};
    assign w_eng_off  = r_ilv ? ((r_col[2:0] ^ r_k) & r_mask)
                              : ((r_col[2:0] + r_k) & r_mask);
    assign w_eng_col  = (r_col & ~w_mask_ext) | {{(COL_W-3){1'b0}}, w_eng_off};

    logic             w_issue_rd, w_issue_wr, w_issue_cl3;
    logic [1:0]       w_issue_bank;
    logic [ROW_W-1:0] w_issue_row;
    logic [COL_W-1:0] w_issue_col;
    logic             w_ap_close;
    logic [1:0]       w_ap_bank;
    logic             w_load;

    always_ff @(posedge clk or posedge init) begin
        if (init) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // A new accepted READ/WRITE replaces the engine's beat in the same cycle, so a cut
    // burst never reaches its last beat and its auto-precharge is dropped with it.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue_rd   = 1'b0;
        w_issue_wr   = 1'b0;
        w_issue_bank = r_bank;
        w_issue_row  = r_brow;
        w_issue_col  = w_eng_col;
        w_issue_cl3  = r_cl3;
        w_ap_close   = 1'b0;
        w_ap_bank    = r_bank;
        w_load       = 1'b0;
        if (w_new_rw) begin
            w_issue_rd   = w_new_rd;
            w_issue_wr   = w_new_wr;
            w_issue_bank = bus.sd_ba;
            w_issue_row  = r_row[bus.sd_ba];
            w_issue_col  = bus.sd_a[COL_W-1:0];
            w_issue_cl3  = w_cl3;
            if (w_new_mask == 3'd0) begin
                w_state_nxt = ST_IDLE;
                w_ap_close  = bus.sd_a[10];
                w_ap_bank   = bus.sd_ba;
            end else begin
                w_load      = 1'b1;
                w_state_nxt = w_new_rd ? ST_RD : ST_WR;
            end
        end else if (r_state != ST_IDLE) begin
            w_issue_rd = (r_state == ST_RD);
            w_issue_wr = (r_state == ST_WR);
            if (r_k == r_mask) begin
                w_state_nxt = ST_IDLE;
                w_ap_close  = r_ap;
            end
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_bank <= '0;
            r_brow <= '0;
            r_col  <= '0;
            r_k    <= '0;
            r_mask <= '0;
            r_ilv  <= 1'b0;
            r_ap   <= 1'b0;
            r_cl3  <= 1'b0;
        end else if (w_load) begin
            r_bank <= bus.sd_ba;
            r_brow <= r_row[bus.sd_ba];
            r_col  <= bus.sd_a[COL_W-1:0];
            r_k    <= 3'd1;
            r_mask <= w_new_mask;
            r_ilv  <= w_ilv;
            r_ap   <= bus.sd_a[10];
            r_cl3  <= w_cl3;
        end else if (r_state != ST_IDLE) begin
            r_k <= r_k + 3'd1;
        end
    end

    // Bank open/close, mode, refresh count and sticky error
    logic        r_err;
    logic [15:0] r_rfsh;
    logic        w_err;

    assign w_err = ((w_cmd_rd || w_cmd_wr) && !w_bank_ok)
                 || (w_cmd_act && w_bank_ok)
                 || ((w_cmd_ref || w_cmd_lmr) && (|r_open));

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_open <= '0;
            for (int unsigned i = 0; i < 4; i++) r_row[i] <= '0;
            r_mode <= 13'h0022;
            r_rfsh <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_ap_close) r_open[w_ap_bank] <= 1'b0;
            if (w_cmd_act) begin
                r_open[bus.sd_ba] <= 1'b1;
                r_row[bus.sd_ba]  <= bus.sd_a[ROW_W-1:0];
            end
            if (w_cmd_pre) begin
                if (bus.sd_a[10]) r_open <= '0;
                else              r_open[bus.sd_ba] <= 1'b0;
            end
            if (w_cmd_ref) r_rfsh <= r_rfsh + 16'd1;
            if (w_cmd_lmr) r_mode <= bus.sd_a;
            if (w_err)     r_err  <= 1'b1;
        end
    end

    // Backing RAM, addressed by the low bits of {bank, row, col}
    logic [FULL_W-1:0] w_full_addr;
    logic [MEM_AW-1:0] w_addr;
    logic [15:0]       r_mem [2**MEM_AW];
    logic [15:0]       r_rd_data;
    logic              w_unused;

    assign w_full_addr = {w_issue_bank, w_issue_row, w_issue_col};
    assign w_addr      = w_full_addr[MEM_AW-1:0];
    assign w_unused    = ^w_full_addr[FULL_W-1:MEM_AW];

    always_ff @(posedge clk) begin
        if (w_issue_wr && !init) begin
            if (!bus.sd_dqml) r_mem[w_addr][7:0]  <= bus.sd_dq_in[7:0];
            if (!bus.sd_dqmh) r_mem[w_addr][15:8] <= bus.sd_dq_in[15:8];
        end
        r_rd_data <= r_mem[w_addr];
    end

    // Read pipeline: RAM stage, optional CL3 stage, output register.
    // Each beat carries its own CL tag so a mode change cannot retime beats in flight.
    logic        r_v0, r_c0, r_v1;
    logic [15:0] r_d1;
    logic        r_oe;
    logic [15:0] r_dq;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_v0 <= 1'b0;
            r_c0 <= 1'b0;
            r_v1 <= 1'b0;
            r_d1 <= '0;
            r_oe <= 1'b0;
            r_dq <= '0;
        end else begin
            r_v0 <= w_issue_rd;
            r_c0 <= w_issue_cl3;
            r_v1 <= r_v0 && r_c0;
            r_d1 <= r_rd_data;
            if (r_v1) begin
                r_oe <= 1'b1;
                r_dq <= r_d1;
            end else if (r_v0 && !r_c0) begin
                r_oe <= 1'b1;
                r_dq <= r_rd_data;
            end else begin
                r_oe <= 1'b0;
                r_dq <= '0;
            end
        end
    end

    assign bus.sd_dq_out  = r_dq;
    assign bus.sd_dq_oe   = r_oe;
    assign bus.mode_reg   = r_mode;
    assign bus.rfsh_count = r_rfsh;
    assign bus.proto_err  = r_err;
endmodule
